mcu_sys_ctrl: RTL and testbench
===============================

MCU_SYS_CTRL -- requirements
Module: mcu_sys_ctrl

Interface
REQ-001 Parameter CORE_ID, default 8'h5C, core identifier returned by the version command.
REQ-002 Parameter VERSION, default 8'h01, core version byte.
REQ-003 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mcu_strobe  input  1  one-cycle pulse: a payload byte from the MCU is valid on mcu_din.
REQ-006 mcu_start  input  1  high during the strobe of the first payload byte (the command byte) of a transfer.
REQ-007 mcu_din  input  8  received payload byte.
REQ-008 mcu_dout  output  8  reply byte, shifted out while the MCU sends the next byte.
REQ-009 irq_src  input  8  level interrupt sources from the core; a rising edge sets a pending bit.
REQ-010 mcu_irq  output  1  interrupt line to the MCU.
REQ-011 cfg  output  64  eight 8-bit configuration registers; byte k occupies cfg[8k+7:8k].
REQ-012 core_reset  output  1  core reset request driven by the MCU.
REQ-013 cfg_upd  output  1  one-cycle pulse on every configuration register write.

Function
REQ-014 The state machine SHALL have states IDLE, VER, IRQ, CFG_IDX, CFG_DAT, RST and SKIP.
REQ-015 A strobe with mcu_start=1 SHALL decode mcu_din in every state: 0x01->VER, 0x02->IRQ, 0x03->CFG_IDX, 0x04->RST; any other value ->SKIP.
REQ-016 mcu_dout SHALL update on the clock edge after the strobe, i.e. with one cycle of latency.
REQ-017 VER: after the command byte mcu_dout=CORE_ID; after payload byte 1 mcu_dout=VERSION; after later payload bytes mcu_dout=8'h00.
REQ-018 IRQ: after the command byte mcu_dout=pending&mask. pending SHALL be cleared by exactly those returned bits in the same cycle. After payload byte 1 mcu_dout=mask.
REQ-019 IRQ: payload byte 1 SHALL write mask. Later payload bytes SHALL be ignored.
REQ-020 Pending set SHALL win over clear when an irq_src rising edge and a read-clear hit the same bit in the same cycle.
REQ-021 mcu_irq SHALL be the registered OR of (pending & mask).
REQ-022 CFG_IDX: payload byte 1 SHALL load the index from bits [2:0] and move to CFG_DAT. Bits [7:3] SHALL be ignored.
REQ-023 CFG_DAT: each byte SHALL write cfg[index], pulse cfg_upd, and increment the index. The index SHALL wrap from 7 to 0.
REQ-024 During CFG, mcu_dout SHALL be the current value of cfg[index] as it stands after that strobe's update, so the MCU can read back.
REQ-025 RST: payload byte 1 bit0 SHALL set core_reset. Later bytes SHALL be ignored.
REQ-026 In SKIP and IDLE, payload bytes SHALL be ignored and mcu_dout=8'h00.
REQ-027 A new mcu_start SHALL abort any command in progress with no further side effects; a partial CFG_IDX SHALL write nothing.
REQ-028 irq_src SHALL be sampled through a 2-flop synchronizer. Edge detection SHALL use the second flop and its delayed copy.

Reset
REQ-029 On reset: state=IDLE, mcu_dout=0, pending=0, mask=0, mcu_irq=0, cfg=all 0, index=0, cfg_upd=0.
REQ-030 On reset, core_reset=1 (core held until the MCU releases it).
REQ-031 On reset, the synchronizer flops SHALL be cleared. A source already high at reset release SHALL NOT set pending.

Structure
REQ-032 A shared package SHALL hold the command codes (CMD_VER, CMD_IRQ, CMD_CFG, CMD_RST), the state enumeration and NUM_CFG=8.
REQ-033 A single sub-module, mcu_irq_ctrl, SHALL contain the synchronizer, edge detection, pending/mask logic and mcu_irq.

Verification
REQ-034 Version read: start+0x01, then byte 0x00, then byte 0x00 -> mcu_dout sequence 0x5C, 0x01, 0x00.
REQ-035 Config burst: start+0x03, 0x07, 0xAA, 0xBB -> cfg[7]=0xAA, cfg[0]=0xBB (wrap), two cfg_upd pulses, mcu_dout 0xAA then 0xBB.
REQ-036 IRQ flow: write mask 0x05 via start+0x02, 0x05. Pulse irq_src[0] and irq_src[1] -> mcu_irq=1 within 4 cycles. Then read (start+0x02) -> mcu_dout=0x01, pending[0] cleared, pending[1] kept, mcu_irq=0.
REQ-037 Collision: irq_src[2] rising edge reaches pending in the same cycle as a read-clear of bit 2 -> bit 2 remains pending and mcu_irq stays 1.
REQ-038 Abort/reset: start+0x03, then start+0x04, 0x00 -> no cfg write and core_reset=0. Then reset mid-CFG_DAT burst -> all REQ-029 and REQ-030 values restored next cycle.

Source files
------------

// File: rtl/mcu_sys_ctrl_pkg.sv
// Shared definitions for the MCU system controller: widths, command codes
// and the command-decoder state enumeration.
package mcu_sys_ctrl_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NUM_CFG = 8;
    localparam int unsigned IDX_W   = $clog2(NUM_CFG);
    localparam int unsigned CFG_W   = NUM_CFG * DATA_W;

    localparam logic [DATA_W-1:0] CMD_VER = 8'h01;
    localparam logic [DATA_W-1:0] CMD_IRQ = 8'h02;
    localparam logic [DATA_W-1:0] CMD_CFG = 8'h03;
    localparam logic [DATA_W-1:0] CMD_RST = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VER,
        ST_IRQ,
        ST_CFG_IDX,
        ST_CFG_DAT,
        ST_RST,
        ST_SKIP
    } state_e;

endpackage

// File: rtl/mcu_sys_ctrl_if.sv
// Byte-stream link between the MCU and the system controller.
//   mcu_strobe : one-cycle pulse, mcu_din valid
//   mcu_start  : marks the command byte of a transfer
//   mcu_din    : payload byte from the MCU
//   mcu_dout   : reply byte to the MCU
interface mcu_sys_ctrl_if;
    import mcu_sys_ctrl_pkg::*;

    logic              mcu_strobe;
    logic              mcu_start;
    logic [DATA_W-1:0] mcu_din;
    logic [DATA_W-1:0] mcu_dout;

    modport master (output mcu_strobe, output mcu_start, output mcu_din, input  mcu_dout);
    modport slave  (input  mcu_strobe, input  mcu_start, input  mcu_din, output mcu_dout);
endinterface

// File: rtl/mcu_irq_ctrl.sv
// Interrupt block: synchronizes level sources, detects rising edges, keeps
// pending/mask registers and drives the interrupt line.
//   irq_src_i      : asynchronous level sources
//   rd_clr_i       : read-clear of the currently returned (pending & mask) bits
//   mask_we_i/_wdata_i : mask register write
//   pend_masked_c  : combinational pending & mask (reply data for a read)
//   mcu_irq_o      : registered OR of pending & mask
module mcu_irq_ctrl
    import mcu_sys_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] irq_src_i,
    input  logic              rd_clr_i,
    input  logic              mask_we_i,
    input  logic [DATA_W-1:0] mask_wdata_i,
    output logic [DATA_W-1:0] pend_masked_c,
    output logic              mcu_irq_o
);

    logic [DATA_W-1:0] sync1_q, sync2_q, dly_q;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] rise_c, clr_c;
    logic [2:0]        arm_q;
    logic              irq_q;

    // Edges are ignored until the pipeline has refilled after reset, so a
    // source already high at release is not seen as a rising edge.
    assign rise_c        = arm_q[2] ? (sync2_q & ~dly_q) : '0;
    assign clr_c         = rd_clr_i ? (pend_q & mask_q) : '0;
    // Set is applied after clear so a simultaneous edge keeps the bit.
    assign pend_d        = (pend_q & ~clr_c) | rise_c;
    assign mask_d        = mask_we_i ? mask_wdata_i : mask_q;
    assign pend_masked_c = pend_q & mask_q;
    assign mcu_irq_o     = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
            arm_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            arm_q   <= {arm_q[1:0], 1'b1};
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            irq_q   <= |(pend_d & mask_d);
        end
    end

endmodule

// File: rtl/mcu_sys_ctrl.sv
// MCU system controller: decodes the MCU byte stream into version read,
// interrupt read/mask, configuration register burst and core reset commands.
//   bus        : MCU byte link (slave side)
//   irq_src    : interrupt sources from the core
//   mcu_irq    : interrupt line to the MCU
//   cfg        : eight configuration bytes, byte k at cfg[8k+7:8k]
//   core_reset : core reset request (set at reset, released by the MCU)
//   cfg_upd    : one-cycle pulse on every configuration write
module mcu_sys_ctrl
    import mcu_sys_ctrl_pkg::*;
#(
    parameter logic [7:0] CORE_ID = 8'h5C,
    parameter logic [7:0] VERSION = 8'h01
) (
    input  logic              clk,
    input  logic              reset,
    mcu_sys_ctrl_if.slave     bus,
    input  logic [DATA_W-1:0] irq_src,
    output logic              mcu_irq,
    output logic [CFG_W-1:0]  cfg,
    output logic              core_reset,
    output logic              cfg_upd
);

    state_e                          state_q;
    logic [DATA_W-1:0]               dout_q;
    logic [NUM_CFG-1:0][DATA_W-1:0]  cfg_q;
    logic [IDX_W-1:0]                idx_q;
    logic                            core_rst_q;
    logic                            upd_q;
    logic                            irq_rd_c;
    logic                            mask_we_c;
    logic [DATA_W-1:0]               pend_masked_c;

    assign irq_rd_c  = bus.mcu_strobe & bus.mcu_start & (bus.mcu_din == CMD_IRQ);
    assign mask_we_c = bus.mcu_strobe & ~bus.mcu_start & (state_q == ST_IRQ);

    mcu_irq_ctrl u_irq (
        .clk           (clk),
        .reset         (reset),
        .irq_src_i     (irq_src),
        .rd_clr_i      (irq_rd_c),
        .mask_we_i     (mask_we_c),
        .mask_wdata_i  (bus.mcu_din),
        .pend_masked_c (pend_masked_c),
        .mcu_irq_o     (mcu_irq)
    );

    assign bus.mcu_dout = dout_q;
    assign cfg          = cfg_q;
    assign core_reset   = core_rst_q;
    assign cfg_upd      = upd_q;

    // Command decoder. One-shot commands fall into SKIP after their last
    // meaningful byte, which also yields 0x00 replies for extra bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dout_q     <= '0;
            cfg_q      <= '0;
            idx_q      <= '0;
            core_rst_q <= 1'b1;
            upd_q      <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (bus.mcu_strobe) begin
                if (bus.mcu_start) begin
                    case (bus.mcu_din)
                        CMD_VER: begin
                            state_q <= ST_VER;
                            dout_q  <= CORE_ID;
                        end
                        CMD_IRQ: begin
                            state_q <= ST_IRQ;
                            dout_q  <= pend_masked_c;
                        end
                        CMD_CFG: begin
                            state_q <= ST_CFG_IDX;
                            dout_q  <= cfg_q[idx_q];
                        end
                        CMD_RST: begin
                            state_q <= ST_RST;
                            dout_q  <= '0;
                        end
                        default: begin
                            state_q <= ST_SKIP;
                            dout_q  <= '0;
                        end
                    endcase
                end else begin
                    case (state_q)
                        ST_VER: begin
                            state_q <= ST_SKIP;
                            dout_q  <= VERSION;
                        end
                        ST_IRQ: begin
                            state_q <= ST_SKIP;
                            dout_q  <= bus.mcu_din;
                        end
                        ST_CFG_IDX: begin
                            state_q <= ST_CFG_DAT;
                            idx_q   <= bus.mcu_din[IDX_W-1:0];
                            dout_q  <= cfg_q[bus.mcu_din[IDX_W-1:0]];
                        end
                        ST_CFG_DAT: begin
                            cfg_q[idx_q] <= bus.mcu_din;
                            upd_q        <= 1'b1;
                            idx_q        <= idx_q + IDX_W'(1);
                            dout_q       <= bus.mcu_din;
                        end
                        ST_RST: begin
                            state_q    <= ST_SKIP;
                            core_rst_q <= bus.mcu_din[0];
                            dout_q     <= '0;
                        end
                        default: begin
                            dout_q <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_sys_ctrl.sv
// Bench for mcu_sys_ctrl: reply bytes are checked by a scoreboard monitor,
// side-band outputs are checked directly by the stimulus process.
module tb_mcu_sys_ctrl;
    import mcu_sys_ctrl_pkg::*;

    typedef struct {
        bit         chk;
        logic [7:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic        mcu_irq;
    logic [63:0] cfg;
    logic        core_reset;
    logic        cfg_upd;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   upd_cnt = 0;
    exp_t sb[$];

    mcu_sys_ctrl_if bus ();

    mcu_sys_ctrl #(.CORE_ID(8'h5C), .VERSION(8'h01)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .irq_src    (irq_src),
        .mcu_irq    (mcu_irq),
        .cfg        (cfg),
        .core_reset (core_reset),
        .cfg_upd    (cfg_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reply monitor: every accepted strobe produces one reply a cycle later.
    always @(posedge clk) begin
        if (bus.mcu_strobe === 1'b1 && reset === 1'b0) begin
            #1;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dout_unexpected: got %0h with empty scoreboard", bus.mcu_dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) check("dout", 64'(bus.mcu_dout), 64'(e.val));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cfg_upd === 1'b1) upd_cnt++;
    end

    task automatic send(input logic st, input logic [7:0] d, input bit chk, input logic [7:0] exp);
        exp_t e;
        e.chk = chk;
        e.val = exp;
        sb.push_back(e);
        @(negedge clk);
        bus.mcu_strobe = 1'b1;
        bus.mcu_start  = st;
        bus.mcu_din    = d;
        @(negedge clk);
        bus.mcu_strobe = 1'b0;
        bus.mcu_start  = 1'b0;
        bus.mcu_din    = 8'h00;
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        @(negedge clk);
        irq_src = irq_src | bits;
        @(negedge clk);
        irq_src = irq_src & ~bits;
    endtask

    task automatic wait_irq(input string name, input logic lvl, input int budget);
        int i = 0;
        while (mcu_irq !== lvl && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 64'(mcu_irq), 64'(lvl));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dout"},    64'(bus.mcu_dout), 64'h0);
        check({tag, "_cfg"},     cfg, 64'h0);
        check({tag, "_corerst"}, 64'(core_reset), 64'h1);
        check({tag, "_irq"},     64'(mcu_irq), 64'h0);
        check({tag, "_upd"},     64'(cfg_upd), 64'h0);
    endtask

    initial begin
        int upd0;
        reset          = 1'b1;
        irq_src        = 8'h00;
        bus.mcu_strobe = 1'b0;
        bus.mcu_start  = 1'b0;
        bus.mcu_din    = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst0");

        // Version read
        send(1'b1, CMD_VER, 1'b1, 8'h5C);
        send(1'b0, 8'h00,   1'b1, 8'h01);
        send(1'b0, 8'h00,   1'b1, 8'h00);

        // Config burst wrapping from index 7 to 0
        upd0 = upd_cnt;
        send(1'b1, CMD_CFG, 1'b0, 8'h00);
        send(1'b0, 8'h07,   1'b1, 8'h00);
        send(1'b0, 8'hAA,   1'b1, 8'hAA);
        send(1'b0, 8'hBB,   1'b1, 8'hBB);
        @(negedge clk);
        check("cfg_burst", cfg, 64'hAA00_0000_0000_00BB);
        check("upd_pulses", 64'(upd_cnt - upd0), 64'd2);

        // Aborted CFG followed by core release
        upd0 = upd_cnt;
        send(1'b1, CMD_CFG, 1'b0, 8'h00);
        send(1'b1, CMD_RST, 1'b0, 8'h00);
        send(1'b0, 8'h00,   1'b0, 8'h00);
        @(negedge clk);
        check("abort_cfg", cfg, 64'hAA00_0000_0000_00BB);
        check("abort_upd", 64'(upd_cnt - upd0), 64'd0);
        check("core_release", 64'(core_reset), 64'h0);

        // Unknown command ignored
        send(1'b1, 8'h7E, 1'b1, 8'h00);
        send(1'b0, 8'h55, 1'b1, 8'h00);

        // IRQ mask write, then pending / read-clear
        send(1'b1, CMD_IRQ, 1'b1, 8'h00);
        send(1'b0, 8'h05,   1'b1, 8'h05);
        pulse_irq(8'h03);
        wait_irq("irq_set", 1'b1, 4);
        send(1'b1, CMD_IRQ, 1'b1, 8'h01);
        @(negedge clk);
        check("irq_cleared", 64'(mcu_irq), 64'h0);
        // Unmask bit 1 to show it stayed pending
        send(1'b1, CMD_IRQ, 1'b1, 8'h00);
        send(1'b0, 8'h02,   1'b1, 8'h02);
        wait_irq("irq_bit1_kept", 1'b1, 3);
        send(1'b1, CMD_IRQ, 1'b1, 8'h02);
        @(negedge clk);
        check("irq_bit1_cleared", 64'(mcu_irq), 64'h0);
        send(1'b1, CMD_IRQ, 1'b1, 8'h00);
        send(1'b0, 8'h05,   1'b1, 8'h05);

        // Collision: new edge on bit 2 lands on the read-clear cycle
        pulse_irq(8'h04);
        wait_irq("irq_bit2", 1'b1, 4);
        repeat (5) @(negedge clk);
        irq_src = 8'h04;
        @(negedge clk);
        send(1'b1, CMD_IRQ, 1'b1, 8'h04);
        irq_src = 8'h00;
        check("collision_irq", 64'(mcu_irq), 64'h1);
        repeat (3) @(negedge clk);
        check("collision_irq_hold", 64'(mcu_irq), 64'h1);
        send(1'b1, CMD_IRQ, 1'b1, 8'h04);
        @(negedge clk);
        check("collision_cleared", 64'(mcu_irq), 64'h0);

        // Reset in the middle of a CFG_DAT burst, with a source held high
        irq_src = 8'h08;
        send(1'b1, CMD_CFG, 1'b0, 8'h00);
        send(1'b0, 8'h02,   1'b1, 8'h00);
        send(1'b0, 8'h11,   1'b1, 8'h11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst1");

        // Source high through reset release must not raise pending
        send(1'b1, CMD_IRQ, 1'b1, 8'h00);
        send(1'b0, 8'hFF,   1'b1, 8'hFF);
        repeat (6) @(negedge clk);
        check("no_edge_after_rst", 64'(mcu_irq), 64'h0);
        send(1'b1, CMD_IRQ, 1'b1, 8'h00);
        irq_src = 8'h00;
        repeat (4) @(negedge clk);
        pulse_irq(8'h08);
        wait_irq("edge_after_rst", 1'b1, 4);

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
